// File: rtl/vit_pkg.sv
// Shared types and defaults for the Viterbi output reorder stage.
package vit_pkg;

  localparam int DEF_BLK_LEN = 64;
  localparam int DEF_ADDR_W  = $clog2(DEF_BLK_LEN);

  typedef logic                  bank_idx_t;
  typedef logic [DEF_ADDR_W-1:0] blk_addr_t;

endpackage

// File: rtl/vit_out_reorder_if.sv
// Traceback-side and consumer-side signals of the reorder stage.
// With VIT_REORDER_BLKCNT_EN defined, the bus also carries the block counter.
interface vit_out_reorder_if;

  logic enable;
  logic selection;
  logic d_in;
  logic wr_en_in;
  logic d_o;
  logic valid_o;
  logic ready_i;
  logic overflow;
`ifdef VIT_REORDER_BLKCNT_EN
  logic [15:0] blk_cnt;

  modport master (
    output enable, selection, d_in, wr_en_in, ready_i,
    input  d_o, valid_o, overflow, blk_cnt
  );
  modport slave (
    input  enable, selection, d_in, wr_en_in, ready_i,
    output d_o, valid_o, overflow, blk_cnt
  );
`else
  modport master (
    output enable, selection, d_in, wr_en_in, ready_i,
    input  d_o, valid_o, overflow
  );
  modport slave (
    input  enable, selection, d_in, wr_en_in, ready_i,
    output d_o, valid_o, overflow
  );
`endif

endinterface

// File: rtl/vit_reorder_bank.sv
// Bit storage for both ping-pong banks (bank index is the address MSB).
// Registered read port; the read register is the stage's output bit.
module vit_reorder_bank #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= 1'b0;
    else if (clr)   rd_data <= 1'b0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vit_out_reorder.sv
// Reverses newest-first traceback blocks into time order using two ping-pong banks.
// Optional block counter output enabled by VIT_REORDER_BLKCNT_EN.
module vit_out_reorder
  import vit_pkg::*;
#(
  parameter int BLK_LEN = DEF_BLK_LEN
) (
  input logic              clk,
  input logic              rst,
  vit_out_reorder_if.slave bus
);

  localparam int                ADDR_W = $clog2(BLK_LEN);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(BLK_LEN - 1);

  bank_idx_t         wbank, wbank_n, rbank, rbank_n;
  logic [ADDR_W-1:0] wptr, wptr_n, rptr, rptr_n;
  logic [1:0]        bank_full, full_n;
  logic              valid_q, valid_n, ovf_q, ovf_n, sel_d;
  logic              restart, accept_slot, load, rd_last, wr_req, wr_ok;

  always_comb begin
    restart     = sel_d & ~bus.selection;
    accept_slot = ~valid_q | bus.ready_i;
    load        = accept_slot & bank_full[rbank];
    rd_last     = load & (rptr == LAST);
    full_n      = bank_full;
    wbank_n     = wbank;
    wptr_n      = wptr;
    rbank_n     = rbank;
    rptr_n      = rptr;
    valid_n     = valid_q;
    ovf_n       = ovf_q;

    // A bank emptied by the read side this cycle is writable this cycle.
    if (rd_last) full_n[rbank] = 1'b0;
    wr_req = bus.wr_en_in & ~restart;
    wr_ok  = wr_req & ~full_n[wbank];

    if (restart) begin
      wptr_n = LAST;
    end else if (wr_req) begin
      // Pointer advances even for dropped bits so block framing stays aligned.
      wptr_n = wptr - ADDR_W'(1);
      if (!wr_ok) begin
        ovf_n = 1'b1;
      end else if (wptr == '0) begin
        full_n[wbank] = 1'b1;
        wbank_n       = ~wbank;
      end
    end

    if (load) begin
      valid_n = 1'b1;
      if (rd_last) begin
        rptr_n  = '0;
        rbank_n = ~rbank;
      end else begin
        rptr_n = rptr + ADDR_W'(1);
      end
    end else if (accept_slot) begin
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbank     <= 1'b0;
      wptr      <= LAST;
      rbank     <= 1'b0;
      rptr      <= '0;
      bank_full <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      sel_d     <= 1'b0;
    end else if (!bus.enable) begin
      wbank     <= 1'b0;
      wptr      <= LAST;
      rbank     <= 1'b0;
      rptr      <= '0;
      bank_full <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      sel_d     <= 1'b0;
    end else begin
      wbank     <= wbank_n;
      wptr      <= wptr_n;
      rbank     <= rbank_n;
      rptr      <= rptr_n;
      bank_full <= full_n;
      valid_q   <= valid_n;
      ovf_q     <= ovf_n;
      sel_d     <= bus.selection;
    end
  end

  vit_reorder_bank #(
    .DEPTH (2 * BLK_LEN),
    .AW    (ADDR_W + 1)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .clr     (~bus.enable),
    .wr_en   (wr_ok & bus.enable),
    .wr_addr ({wbank, wptr}),
    .wr_data (bus.d_in),
    .rd_en   (load),
    .rd_addr ({rbank, rptr}),
    .rd_data (bus.d_o)
  );

  assign bus.valid_o  = valid_q;
  assign bus.overflow = ovf_q;

`ifdef VIT_REORDER_BLKCNT_EN
  logic        last_q;
  logic [15:0] cnt_q;

  // last_q marks that the bit on d_o closes its block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else if (!bus.enable) begin
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (valid_q && bus.ready_i && last_q) cnt_q <= cnt_q + 16'd1;
      if (load) last_q <= rd_last;
    end
  end

  assign bus.blk_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_vit_out_reorder.sv
// Self-checking bench for vit_out_reorder (BLK_LEN=8); queue-based block-reversal model.
module tb_vit_out_reorder;

  localparam int BLK = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  vit_out_reorder_if bus ();

  vit_out_reorder #(.BLK_LEN(BLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];
  bit cur[$];
  bit sel_last  = 1'b0;
  bit exp_ovf   = 1'b0;
  bit drop_blk  = 1'b0;
  bit chk_cont  = 1'b0;
  bit rnd_ready = 1'b0;
  int acc_cnt   = 0;
  int out_pos   = 0;
  int exp_blk   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    cur.delete();
    exp_ovf  = 1'b0;
    sel_last = 1'b0;
    out_pos  = 0;
    exp_blk  = 0;
  endtask

  // Each accepted bit must be the next one of the time-ordered stream.
  always @(negedge clk) begin
`ifdef VIT_REORDER_BLKCNT_EN
    check("blk_cnt", bus.blk_cnt, 16'(exp_blk));
`endif
    if (chk_cont) check("valid_cont", bus.valid_o, 1);
    if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
      check("out_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("d_o", bus.d_o, exp_q.pop_front());
        acc_cnt++;
        out_pos++;
        if (out_pos % BLK == 0) exp_blk++;
      end
    end
  end

  // One clock of stimulus; the model applies the same clock's effects.
  task automatic cycle(input bit wr, input bit b);
    bit restart_now;
    restart_now = sel_last && !bus.selection;
    bus.wr_en_in = wr;
    bus.d_in     = b;
    @(posedge clk);
    #1;
    bus.wr_en_in = 1'b0;
    if (!bus.enable) begin
      model_clear();
    end else begin
      sel_last = bus.selection;
      if (restart_now) begin
        cur.delete();
      end else if (wr) begin
        cur.push_back(b);
        if (cur.size() == BLK) begin
          if (drop_blk) exp_ovf = 1'b1;
          else for (int i = BLK - 1; i >= 0; i--) exp_q.push_back(cur[i]);
          cur.delete();
        end
      end
    end
    if (rnd_ready) bus.ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic write_block(input logic [BLK-1:0] v);
    for (int i = BLK - 1; i >= 0; i--) cycle(1'b1, v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  task automatic wait_out(input int limit);
    int n = 0;
    while (exp_q.size() > limit && n < 400) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check("drain_bound", exp_q.size() <= limit, 1);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 100) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check("acc_bound", acc_cnt >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    bit bits[24];

    bus.enable    = 1'b1;
    bus.selection = 1'b0;
    bus.d_in      = 1'b0;
    bus.wr_en_in  = 1'b0;
    bus.ready_i   = 1'b1;

    #12;
    check("rst_valid", bus.valid_o, 0);
    check("rst_d_o", bus.d_o, 0);
    check("rst_ovf", bus.overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic reverse and first-bit latency
    write_block(8'b10110010);
    check("basic_pre_valid", bus.valid_o, 0);
    cycle(1'b0, 1'b0);
    check("basic_first_valid", bus.valid_o, 1);
    check("basic_first_bit", bus.d_o, 0);
    wait_out(0);
    idle(2);
    check("basic_idle", bus.valid_o, 0);

    // Three back-to-back blocks, continuous output
    for (int k = 0; k < 24; k++) bits[k] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 24; k++) begin
      cycle(1'b1, bits[k]);
      if (k == BLK) chk_cont = 1'b1;
    end
    idle(BLK);
    chk_cont = 1'b0;
    wait_out(0);
    idle(2);
    check("pp_idle", bus.valid_o, 0);
    check("pp_ovf", bus.overflow, 0);

    // Backpressure: third block arrives with both banks full
    bus.ready_i = 1'b0;
    write_block(8'($urandom));
    write_block(8'($urandom));
    drop_blk = 1'b1;
    write_block(8'($urandom));
    drop_blk = 1'b0;
    check("ovf_set", bus.overflow, exp_ovf);
    check("ovf_hold_valid", bus.valid_o, 1);
    check("ovf_hold_bit", bus.d_o, exp_q[0]);
    idle(3);
    check("ovf_hold_bit2", bus.d_o, exp_q[0]);
    check("ovf_queue_len", exp_q.size(), 2 * BLK);
    bus.ready_i = 1'b1;
    wait_out(0);
    idle(2);
    check("ovf_empty", bus.valid_o, 0);
    check("ovf_sticky", bus.overflow, exp_ovf);

    // Async reset in the middle of a block readout
    write_block(8'($urandom));
    wait_acc(acc_cnt + 3);
    rst = 1'b0;
    #2;
    check("mid_rst_valid", bus.valid_o, 0);
    check("mid_rst_d_o", bus.d_o, 0);
    check("mid_rst_ovf", bus.overflow, 0);
    rst = 1'b1;
    model_clear();
    write_block(8'b11001010);
    wait_out(0);
    idle(2);
    check("post_rst_idle", bus.valid_o, 0);

    // Synchronous clear through enable
    write_block(8'($urandom));
    wait_acc(acc_cnt + 3);
    bus.enable = 1'b0;
    cycle(1'b0, 1'b0);
    check("en_clr_valid", bus.valid_o, 0);
    check("en_clr_d_o", bus.d_o, 0);
    check("en_clr_ovf", bus.overflow, 0);
    bus.enable = 1'b1;
    write_block(8'b01101001);
    wait_out(0);
    idle(2);
    check("post_en_idle", bus.valid_o, 0);

    // Restart discards a partial block; coincident write is dropped
    bus.selection = 1'b1;
    cycle(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'($urandom_range(0, 1)));
    a0 = acc_cnt;
    bus.selection = 1'b0;
    cycle(1'b1, 1'b1);
    write_block(8'b11110000);
    wait_out(0);
    idle(2);
    check("restart_count", acc_cnt - a0, BLK);
    check("restart_ovf", bus.overflow, 0);

    // Random stream: random gaps, backpressure and restarts
    rnd_ready = 1'b1;
    for (int n = 0; n < 30 * BLK; n++) begin
      if (cur.size() == 0) wait_out(BLK);
      while ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b0);
      if ($urandom_range(0, 15) == 0) bus.selection = ~bus.selection;
      cycle(1'b1, 1'($urandom_range(0, 1)));
    end
    rnd_ready   = 1'b0;
    bus.ready_i = 1'b1;
    wait_out(0);
    idle(2);
    check("rand_idle", bus.valid_o, 0);
    check("rand_ovf", bus.overflow, exp_ovf);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
